imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Pipelined, elastic immediate generator for the RV32IC core; the next generation of the single-cycle immediate decoder. Accepts one 32-bit fetch word per handshake and decodes either a full 32-bit or a compressed 16-bit instruction. Emits the sign- or zero-extended immediate, an immediate-type tag, an is-compressed flag and an illegal flag. Sits between fetch/align and the ALU/branch operand muxes, with valid/ready on both sides and configurable latency.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64; sign extension fills to XLEN.
SUPPORT_C, 1, decode RVC immediates when 1; when 0, inst[1:0]!=2'b11 is flagged illegal.
STAGES, 2, pipeline depth; legal values are 1 (decode and output register) and 2 (field-extract register, then immediate register).

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  inst is valid
in_ready  output  1  block can accept inst this cycle
inst  input  32  instruction word; the compressed form is in inst[15:0]
out_valid  output  1  outputs hold a result
out_ready  input  1  consumer accepts result
imm_out  output  XLEN  generated immediate
imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
is_compressed  output  1  inst[1:0]!=2'b11
illegal  output  1  opcode or compressed encoding has no defined immediate form

Behaviour:
- Reset, asynchronous: all stage valids are 0, out_valid=0, imm_out=0, imm_type=0, is_compressed=0, illegal=0. Asserting rst mid-operation discards all in-flight entries with no output.
- Handshake: a transfer occurs when valid&&ready.
  - Stage k loads when it is empty or the downstream stage is taking its entry this cycle.
  - in_ready = !s1_valid || s1_advance. in_ready is combinational from out_ready (no skid).
  - Full throughput: one result per cycle while out_ready=1.
  - Latency is STAGES cycles from the accepting edge to out_valid.
  - Ordering is strict FIFO.
  - Outputs hold stable while out_valid&&!out_ready.
- 32-bit decode, by opcode:
  - I-type: opcodes 0000011, 1100111, 0010011, 1110011. imm = sext(inst[31:20]).
  - SHAMT: opcode 0010011 with funct3 001 or 101. imm = zext(inst[24:20]), for SLLI, SRLI and SRAI; inst[30] never reaches imm.
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: opcodes 0110111 and 0010111. {inst[31:12],12'b0}, sign-extended to XLEN.
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Opcodes with no immediate (0110011, 0001111): imm 0, type NONE, illegal 0.
  - Any other opcode: imm 0, type NONE, illegal 1.
  - Every path assigns imm; no latches.
- Compressed decode (SUPPORT_C=1). imm_type reports the expanded-equivalent type.
  - C.ADDI4SPN: zext nzuimm[9:2]; nzuimm=0 is illegal.
  - C.LW/C.SW: zext uimm[6:2].
  - C.ADDI/C.LI/C.ANDI: sext imm[5:0].
  - C.LUI: sext nzimm[17:12]<<12.
  - C.ADDI16SP (rd=2): sext nzimm[9:4]; zero value is illegal.
  - C.SLLI/C.SRLI/C.SRAI: zext shamt; shamt[5]=1 is illegal for RV32.
  - C.J/C.JAL: sext offset[11:1].
  - C.BEQZ/C.BNEZ: sext offset[8:1].
  - C.LWSP: zext uimm[7:2]. C.SWSP: zext uimm[7:2].
  - Register-only forms (C.MV, C.ADD, C.JR, C.JALR, C.SUB and the rest of that group): type NONE, illegal 0.
  - inst[15:0]==16'h0000 is illegal.
  - inst[31:16] is ignored when the instruction is compressed.
- Illegal entries still flow through the pipeline and handshake normally, with illegal=1 and imm=0.

Decomposition:
- Shared package imm_pkg holds:
  - the imm_type encoding constants;
  - the 32-bit opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_JAL, OP_BRANCH, OP_STORE, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - the RVC quadrant and funct3 constants.
- One sub-module, rvc_imm_decode: purely combinational compressed-immediate extraction. It is instantiated once before stage 1; the top module owns all registers and handshake logic.

Test Plan:
1. JAL 0xFFDFF06F, out_ready=1 -> after STAGES cycles imm_out=0xFFFFFFFC, imm_type=J, is_compressed=0, illegal=0.
2. SRAI 0x4030D093 -> imm_out=0x00000003, type SHAMT. ADDI 0xFFF00093 -> imm_out=0xFFFFFFFF, type I.
3. LUI 0x123452B7 -> 0x12345000, type U. C.J 0xBFFD -> 0xFFFFFFFE, type J, is_compressed=1.
4. C.LWSP 0x4092 -> imm_out=0x00000004, type I. Word 0x00000000 -> illegal=1, imm_out=0. With SUPPORT_C=0, 0x4092 -> illegal=1.
5. Back-to-back stream of 5 instructions, out_ready held low for 3 cycles:
   - in_ready falls once all stages are full;
   - no result is lost or duplicated;
   - outputs are stable while stalled;
   - order is preserved;
   - 1 result per cycle resumes when out_ready returns high.
6. rst pulsed asynchronously (mid-cycle) while 2 entries are in flight -> out_valid=0 immediately, all outputs 0; the next accepted instruction emerges after exactly STAGES cycles.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-type tags, RV32 opcodes and RVC quadrant/funct3 constants
package imm_pkg;
  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_J     = 3'd5;
  localparam logic [2:0] IMM_SHAMT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C0_ADDI4SPN = 3'd0;
  localparam logic [2:0] C0_LW       = 3'd2;
  localparam logic [2:0] C0_SW       = 3'd6;
  localparam logic [2:0] C1_ADDI     = 3'd0;
  localparam logic [2:0] C1_JAL      = 3'd1;
  localparam logic [2:0] C1_LI       = 3'd2;
  localparam logic [2:0] C1_LUI      = 3'd3;
  localparam logic [2:0] C1_ARITH    = 3'd4;
  localparam logic [2:0] C1_J        = 3'd5;
  localparam logic [2:0] C2_SLLI     = 3'd0;
  localparam logic [2:0] C2_LWSP     = 3'd2;
  localparam logic [2:0] C2_CR       = 3'd4;
  localparam logic [2:0] C2_SWSP     = 3'd6;
endpackage

// File: rtl/rvc_imm_decode.sv
// rvc_imm_decode: combinational immediate extraction for 16-bit RVC encodings
module rvc_imm_decode #(
  parameter bit SUPPORT_C = 1'b1
) (
  input  logic [15:0] inst,
  output logic [31:0] imm,
  output logic [2:0]  imm_type,
  output logic        is_c,
  output logic        illegal
);
  import imm_pkg::*;
  logic [2:0]  f3;
  logic [31:0] imm6;
  logic [31:0] raw;
  logic [2:0]  typ;
  logic        ill;
  assign f3   = inst[15:13];
  assign imm6 = {{26{inst[12]}}, inst[12], inst[6:2]};
  assign is_c = inst[1:0] != 2'b11;
  // Scatter/gather the immediate per quadrant and funct3; raw is already extended to 32 bits
  always_comb begin
    raw = '0;
    typ = IMM_NONE;
    ill = 1'b0;
    case (inst[1:0])
      RVC_Q0: case (f3)
        C0_ADDI4SPN: begin
          raw = {22'd0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
          typ = IMM_I;
          ill = inst[12:5] == 8'd0;
        end
        C0_LW, C0_SW: begin
          raw = {25'd0, inst[5], inst[12:10], inst[6], 2'b00};
          typ = f3 == C0_LW ? IMM_I : IMM_S;
        end
        default: ill = 1'b1;
      endcase
      RVC_Q1: case (f3)
        C1_ADDI, C1_LI: begin
          raw = imm6;
          typ = IMM_I;
        end
        C1_JAL, C1_J: begin
          raw = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 1'b0};
          typ = IMM_J;
        end
        C1_LUI: if (inst[11:7] == 5'd2) begin
          raw = {{22{inst[12]}}, inst[12], inst[4:3], inst[5], inst[2], inst[6], 4'd0};
          typ = IMM_I;
          ill = {inst[12], inst[6:2]} == 6'd0;
        end else begin
          raw = {{14{inst[12]}}, inst[12], inst[6:2], 12'd0};
          typ = IMM_U;
        end
        C1_ARITH: case (inst[11:10])
          2'b00, 2'b01: begin
            raw = {26'd0, inst[12], inst[6:2]};
            typ = IMM_SHAMT;
            ill = inst[12];
          end
          2'b10: begin
            raw = imm6;
            typ = IMM_I;
          end
          default: ;
        endcase
        default: begin
          raw = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
          typ = IMM_B;
        end
      endcase
      RVC_Q2: case (f3)
        C2_SLLI: begin
          raw = {26'd0, inst[12], inst[6:2]};
          typ = IMM_SHAMT;
          ill = inst[12];
        end
        C2_LWSP: begin
          raw = {24'd0, inst[3:2], inst[12], inst[6:4], 2'b00};
          typ = IMM_I;
        end
        C2_SWSP: begin
          raw = {24'd0, inst[8:7], inst[12:9], 2'b00};
          typ = IMM_S;
        end
        C2_CR: ;
        default: ill = 1'b1;
      endcase
      default: ;
    endcase
  end
  assign illegal  = ill || !SUPPORT_C;
  assign imm      = illegal ? '0 : raw;
  assign imm_type = illegal ? IMM_NONE : typ;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: elastic 1- or 2-stage RV32IC immediate generator with valid/ready on both sides
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_C = 1'b1,
  parameter int STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_type,
  output logic            is_compressed,
  output logic            illegal
);
  import imm_pkg::*;
  logic [31:0]     c_imm, m_inst, m_cimm, f_imm;
  logic [2:0]      c_type, m_ctype, f_type;
  logic            c_isc, c_ill, m_isc, m_cill, f_ill, m_valid, o_load;
  logic            out_valid_q, out_valid_d, is_c_q, is_c_d, ill_q, ill_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      type_q, type_d;

  rvc_imm_decode #(.SUPPORT_C(SUPPORT_C)) u_rvc (
    .inst     (inst[15:0]),
    .imm      (c_imm),
    .imm_type (c_type),
    .is_c     (c_isc),
    .illegal  (c_ill)
  );

  assign o_load = !out_valid_q || out_ready;

  if (STAGES == 2) begin : g_s1
    logic        s1_valid_q, s1_valid_d, s1_isc_q, s1_isc_d, s1_ill_q, s1_ill_d, take;
    logic [31:0] s1_inst_q, s1_inst_d, s1_imm_q, s1_imm_d;
    logic [2:0]  s1_type_q, s1_type_d;
    assign in_ready = !s1_valid_q || o_load;
    assign take     = in_valid && in_ready;
    // Field-extract stage: holds the raw word plus the already-decoded RVC result
    always_comb begin
      s1_valid_d = in_ready ? in_valid : s1_valid_q;
      s1_inst_d  = take ? inst : s1_inst_q;
      s1_imm_d   = take ? c_imm : s1_imm_q;
      s1_type_d  = take ? c_type : s1_type_q;
      s1_isc_d   = take ? c_isc : s1_isc_q;
      s1_ill_d   = take ? c_ill : s1_ill_q;
    end
    // Stage-1 registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_inst_q  <= '0;
        s1_imm_q   <= '0;
        s1_type_q  <= IMM_NONE;
        s1_isc_q   <= 1'b0;
        s1_ill_q   <= 1'b0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_inst_q  <= s1_inst_d;
        s1_imm_q   <= s1_imm_d;
        s1_type_q  <= s1_type_d;
        s1_isc_q   <= s1_isc_d;
        s1_ill_q   <= s1_ill_d;
      end
    end
    assign m_valid = s1_valid_q;
    assign m_inst  = s1_inst_q;
    assign m_cimm  = s1_imm_q;
    assign m_ctype = s1_type_q;
    assign m_isc   = s1_isc_q;
    assign m_cill  = s1_ill_q;
  end else begin : g_s0
    assign in_ready = o_load;
    assign m_valid  = in_valid;
    assign m_inst   = inst;
    assign m_cimm   = c_imm;
    assign m_ctype  = c_type;
    assign m_isc    = c_isc;
    assign m_cill   = c_ill;
  end

  // 32-bit immediate decode by major opcode; unknown opcodes yield illegal with a zero immediate
  always_comb begin
    f_imm  = '0;
    f_type = IMM_NONE;
    f_ill  = 1'b0;
    case (m_inst[6:0])
      OP_IMM: if (m_inst[14:12] == F3_SLLI || m_inst[14:12] == F3_SRXI) begin
        f_imm  = {27'd0, m_inst[24:20]};
        f_type = IMM_SHAMT;
      end else begin
        f_imm  = {{20{m_inst[31]}}, m_inst[31:20]};
        f_type = IMM_I;
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        f_imm  = {{20{m_inst[31]}}, m_inst[31:20]};
        f_type = IMM_I;
      end
      OP_STORE: begin
        f_imm  = {{20{m_inst[31]}}, m_inst[31:25], m_inst[11:7]};
        f_type = IMM_S;
      end
      OP_BRANCH: begin
        f_imm  = {{19{m_inst[31]}}, m_inst[31], m_inst[7], m_inst[30:25], m_inst[11:8], 1'b0};
        f_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        f_imm  = {m_inst[31:12], 12'd0};
        f_type = IMM_U;
      end
      OP_JAL: begin
        f_imm  = {{11{m_inst[31]}}, m_inst[31], m_inst[19:12], m_inst[20], m_inst[30:21], 1'b0};
        f_type = IMM_J;
      end
      OP_REG, OP_FENCE: ;
      default: f_ill = 1'b1;
    endcase
  end

  // Output stage loads the selected decode when empty or being drained, otherwise holds
  always_comb begin
    out_valid_d = o_load ? m_valid : out_valid_q;
    imm_d       = (o_load && m_valid) ? XLEN'($signed(m_isc ? m_cimm : f_imm)) : imm_q;
    type_d      = (o_load && m_valid) ? (m_isc ? m_ctype : f_type) : type_q;
    is_c_d      = (o_load && m_valid) ? m_isc : is_c_q;
    ill_d       = (o_load && m_valid) ? (m_isc ? m_cill : f_ill) : ill_q;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      type_q      <= IMM_NONE;
      is_c_q      <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      type_q      <= type_d;
      is_c_q      <= is_c_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign imm_out       = imm_q;
  assign imm_type      = type_q;
  assign is_compressed = is_c_q;
  assign illegal       = ill_q;
endmodule
